// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write path: width codes and port selects.
package regfile_write_arbiter_pkg;

    localparam int unsigned WIDTH_CODE_W = 4;

    // Width codes understood by the register file
    localparam logic [WIDTH_CODE_W-1:0] BYTE = 4'd1;
    localparam logic [WIDTH_CODE_W-1:0] HALF = 4'd2;
    localparam logic [WIDTH_CODE_W-1:0] WORD = 4'd4;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // True for a width code the register file can commit
    function automatic logic width_legal(input logic [WIDTH_CODE_W-1:0] code);
        return (code == BYTE) || (code == HALF) || (code == WORD);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register owned by the long-latency unit.
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUMBER     = 32,
    parameter int unsigned REG_ADDR_WIDTH = $clog2(REG_NUMBER)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_valid,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr,
    input  logic                      clr_valid,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
    input  logic [REG_ADDR_WIDTH-1:0] query1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] query2_addr,
    output logic                      query1_busy,
    output logic                      query2_busy
);

    logic [REG_NUMBER-1:0] pending_q;
    logic [REG_NUMBER-1:0] pending_d;

    // Clear on the B write leaving the output stage; a same-edge issue re-marks the register
    always_comb begin
        pending_d = pending_q;
        if (clr_valid) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_valid && (set_addr != '0)) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    // Pending vector state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Busy lookups, bypassed by the B write currently presented to the register file
    always_comb begin
        query1_busy = (query1_addr != '0) && pending_q[query1_addr]
                      && !(clr_valid && (clr_addr == query1_addr));
        query2_busy = (query2_addr != '0) && pending_q[query2_addr]
                      && !(clr_valid && (clr_addr == query2_addr));
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between pipeline (A) and mul/div (B).
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUMBER     = 32,
    parameter int unsigned REG_ADDR_WIDTH = $clog2(REG_NUMBER),
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [REG_ADDR_WIDTH-1:0] a_addr,
    input  logic [WIDTH_CODE_W-1:0]   a_width,
    input  logic [DATA_WIDTH-1:0]     a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [REG_ADDR_WIDTH-1:0] b_addr,
    input  logic [WIDTH_CODE_W-1:0]   b_width,
    input  logic [DATA_WIDTH-1:0]     b_data,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_addr,
    input  logic [REG_ADDR_WIDTH-1:0] query1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] query2_addr,
    output logic                      query1_busy,
    output logic                      query2_busy,
    output logic                      rf_write_enable,
    output logic [WIDTH_CODE_W-1:0]   rf_write_width,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_reg_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      width_error
);

    logic                      a_grant_c;
    logic                      b_grant_c;
    logic                      xfer_c;
    logic [REG_ADDR_WIDTH-1:0] sel_addr_c;
    logic [WIDTH_CODE_W-1:0]   sel_width_c;
    logic [DATA_WIDTH-1:0]     sel_data_c;

    port_sel_e                 last_grant_q, last_grant_d;
    logic                      rf_we_q, rf_we_d;
    logic [WIDTH_CODE_W-1:0]   rf_width_q, rf_width_d;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
    logic                      out_b_q, out_b_d;
    logic                      width_error_q, width_error_d;

    // Round-robin grant; nothing is accepted while reset is asserted
    always_comb begin
        a_grant_c = 1'b0;
        b_grant_c = 1'b0;
        if (reset) begin
            if (a_valid && b_valid) begin
                if (last_grant_q == PORT_B) begin
                    a_grant_c = 1'b1;
                end else begin
                    b_grant_c = 1'b1;
                end
            end else begin
                a_grant_c = a_valid;
                b_grant_c = b_valid;
            end
        end
    end

    assign a_ready     = a_grant_c;
    assign b_ready     = b_grant_c;
    assign xfer_c      = a_grant_c || b_grant_c;
    assign sel_addr_c  = b_grant_c ? b_addr  : a_addr;
    assign sel_width_c = b_grant_c ? b_width : a_width;
    assign sel_data_c  = b_grant_c ? b_data  : a_data;

    // Output stage next state: register the winner, suppress r0 and illegal-width commits
    always_comb begin
        rf_we_d       = 1'b0;
        rf_width_d    = rf_width_q;
        rf_addr_d     = rf_addr_q;
        rf_data_d     = rf_data_q;
        out_b_d       = 1'b0;
        width_error_d = width_error_q;
        last_grant_d  = last_grant_q;
        if (xfer_c) begin
            rf_we_d      = width_legal(sel_width_c) && (sel_addr_c != '0);
            rf_width_d   = sel_width_c;
            rf_addr_d    = sel_addr_c;
            rf_data_d    = sel_data_c;
            out_b_d      = b_grant_c;
            last_grant_d = b_grant_c ? PORT_B : PORT_A;
            if (!width_legal(sel_width_c)) begin
                width_error_d = 1'b1;
            end
        end
    end

    // Output stage, sticky error and arbitration history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q       <= 1'b0;
            rf_width_q    <= '0;
            rf_addr_q     <= '0;
            rf_data_q     <= '0;
            out_b_q       <= 1'b0;
            width_error_q <= 1'b0;
            last_grant_q  <= PORT_B;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_width_q    <= rf_width_d;
            rf_addr_q     <= rf_addr_d;
            rf_data_q     <= rf_data_d;
            out_b_q       <= out_b_d;
            width_error_q <= width_error_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign rf_write_enable   = rf_we_q;
    assign rf_write_width    = rf_width_q;
    assign rf_write_reg_addr = rf_addr_q;
    assign rf_write_data     = rf_data_q;
    assign width_error       = width_error_q;

    regfile_scoreboard #(
        .REG_NUMBER     (REG_NUMBER),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (reset),
        .set_valid   (issue_valid),
        .set_addr    (issue_addr),
        .clr_valid   (out_b_q),
        .clr_addr    (rf_addr_q),
        .query1_addr (query1_addr),
        .query2_addr (query2_addr),
        .query1_busy (query1_busy),
        .query2_busy (query2_busy)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, issue_addr, query1_addr, query2_addr, rf_write_reg_addr;
    logic [3:0]  a_width, b_width, rf_write_width;
    logic [31:0] a_data, b_data, rf_write_data;
    logic        issue_valid, query1_busy, query2_busy, rf_write_enable, width_error;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: pending set, last winner, what the output stage currently presents
    bit [31:0]   m_pend;
    bit          m_last_b;
    bit          m_we, m_fromb, m_err, m_a_acc, m_b_acc;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_width;
    logic        pre_a_ready, pre_b_ready;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .a_valid           (a_valid),
        .a_ready           (a_ready),
        .a_addr            (a_addr),
        .a_width           (a_width),
        .a_data            (a_data),
        .b_valid           (b_valid),
        .b_ready           (b_ready),
        .b_addr            (b_addr),
        .b_width           (b_width),
        .b_data            (b_data),
        .issue_valid       (issue_valid),
        .issue_addr        (issue_addr),
        .query1_addr       (query1_addr),
        .query2_addr       (query2_addr),
        .query1_busy       (query1_busy),
        .query2_busy       (query2_busy),
        .rf_write_enable   (rf_write_enable),
        .rf_write_width    (rf_write_width),
        .rf_write_reg_addr (rf_write_reg_addr),
        .rf_write_data     (rf_write_data),
        .width_error       (width_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4);
    endfunction

    function automatic bit exp_a_grant();
        return a_valid && (!b_valid || m_last_b);
    endfunction

    function automatic bit exp_b_grant();
        return b_valid && (!a_valid || !m_last_b);
    endfunction

    function automatic bit exp_busy(input logic [4:0] q);
        return (q != 5'd0) && m_pend[q] && !(m_fromb && (m_addr == q));
    endfunction

    function automatic logic [3:0] rand_width();
        case ($urandom_range(0, 9))
            0, 1, 2: return 4'd1;
            3, 4:    return 4'd2;
            5, 6, 7: return 4'd4;
            8:       return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_last_b = 1'b1; m_we = 1'b0; m_fromb = 1'b0; m_err = 1'b0;
        m_a_acc = 1'b0; m_b_acc = 1'b0; m_addr = '0; m_data = '0; m_width = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_edge();
        bit ga, gb;
        ga = exp_a_grant();
        gb = exp_b_grant();
        if (m_fromb) m_pend[m_addr] = 1'b0;
        if (issue_valid && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
        m_a_acc = ga;
        m_b_acc = gb;
        if (ga || gb) begin
            m_addr   = gb ? b_addr  : a_addr;
            m_width  = gb ? b_width : a_width;
            m_data   = gb ? b_data  : a_data;
            m_we     = legal(m_width) && (m_addr != 5'd0);
            m_fromb  = gb;
            m_last_b = gb;
            if (!legal(m_width)) m_err = 1'b1;
        end else begin
            m_we    = 1'b0;
            m_fromb = 1'b0;
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, "_a_ready"}, a_ready, exp_a_grant());
        chk({tag, "_b_ready"}, b_ready, exp_b_grant());
        chk({tag, "_busy1"}, query1_busy, exp_busy(query1_addr));
        chk({tag, "_busy2"}, query2_busy, exp_busy(query2_addr));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_we"}, rf_write_enable, m_we);
        if (m_we) begin
            chk({tag, "_addr"}, rf_write_reg_addr, m_addr);
            chk({tag, "_data"}, rf_write_data, m_data);
            chk({tag, "_width"}, rf_write_width, m_width);
        end
        chk({tag, "_werr"}, width_error, m_err);
    endtask

    // One cycle: inputs were driven at the preceding falling edge
    task automatic step(input string tag);
        #1;
        pre_a_ready = a_ready;
        pre_b_ready = b_ready;
        check_comb({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_comb({tag, "_post"});
        check_regs(tag);
        @(negedge clk);
        if (m_a_acc) a_data = $urandom;
        if (m_b_acc) b_data = $urandom;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; issue_valid = 0;
    endtask

    initial begin
        reset = 1'b0;
        a_valid = 0; a_addr = 0; a_width = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_width = 0; b_data = 0;
        issue_valid = 0; issue_addr = 0; query1_addr = 0; query2_addr = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_we", rf_write_enable, 0);
        chk("rst_addr", rf_write_reg_addr, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_width", rf_write_width, 0);
        chk("rst_werr", width_error, 0);
        reset = 1'b1;

        // First write from A after reset
        a_valid = 1; a_addr = 5'd5; a_width = 4'd4; a_data = 32'hDEADBEEF;
        step("first");
        chk("first_ready", pre_a_ready, 1);
        chk("first_we", rf_write_enable, 1);
        chk("first_addr", rf_write_reg_addr, 5'd5);
        chk("first_data", rf_write_data, 32'hDEADBEEF);

        // B alone so the following tie starts with A
        a_valid = 0; b_valid = 1; b_addr = 5'd3; b_width = 4'd2;
        step("bonly");

        // Both requesting: alternate A, B, A, B
        a_valid = 1; a_addr = 5'd1; a_width = 4'd4;
        b_valid = 1; b_addr = 5'd2; b_width = 4'd1;
        for (int i = 0; i < 4; i++) begin
            step("rr");
            chk("rr_a_grant", pre_a_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_b_grant", pre_b_ready, (i % 2 == 0) ? 0 : 1);
        end

        // Issue to r7, observe busy, then the B writeback bypasses it
        idle_inputs();
        issue_valid = 1; issue_addr = 5'd7;
        step("iss7");
        issue_valid = 0; query1_addr = 5'd7;
        step("q7");
        chk("busy7", query1_busy, 1);
        b_valid = 1; b_addr = 5'd7; b_width = 4'd4;
        step("wb7");
        chk("wb7_bypass", query1_busy, 0);
        chk("wb7_we", rf_write_enable, 1);
        b_valid = 0;
        step("clr7");
        chk("clr7_busy", query1_busy, 0);

        // Issue to r9 at the edge where a B write to r9 leaves the output stage
        b_valid = 1; b_addr = 5'd9; b_width = 4'd4;
        step("wb9");
        b_valid = 0; issue_valid = 1; issue_addr = 5'd9;
        step("iss9");
        issue_valid = 0; query1_addr = 5'd9;
        step("q9");
        chk("set_wins9", query1_busy, 1);

        // r0 write and illegal width are accepted but never committed
        a_valid = 1; a_addr = 5'd0; a_width = 4'd4;
        step("r0");
        chk("r0_we", rf_write_enable, 0);
        a_addr = 5'd4; a_width = 4'd3;
        step("w3");
        chk("w3_we", rf_write_enable, 0);
        chk("w3_err", width_error, 1);
        a_valid = 0;
        step("sticky");
        chk("sticky_err", width_error, 1);

        // Randomized traffic honouring the hold-while-stalled rule
        for (int i = 0; i < 300; i++) begin
            if (!a_valid || m_a_acc) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 5'($urandom_range(0, 7));
                a_width = rand_width();
                a_data  = $urandom;
            end
            if (!b_valid || m_b_acc) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 5'($urandom_range(0, 7));
                b_width = rand_width();
                b_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_addr  = 5'($urandom_range(0, 7));
            query1_addr = 5'($urandom_range(0, 7));
            query2_addr = 5'($urandom_range(0, 7));
            step("rnd");
        end

        // Reset mid-stream with pending bits and a write in the output stage
        idle_inputs();
        issue_valid = 1; issue_addr = 5'd6;
        step("pre_rst_iss");
        issue_valid = 0;
        b_valid = 1; b_addr = 5'd12; b_width = 4'd2;
        step("pre_rst_wb");
        b_valid = 0; query1_addr = 5'd6; query2_addr = 5'd12;
        a_valid = 1; b_valid = 1; a_addr = 5'd1; b_addr = 5'd2;
        #1;
        chk("pre_rst_busy6", query1_busy, 1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_we", rf_write_enable, 0);
        chk("arst_addr", rf_write_reg_addr, 0);
        chk("arst_data", rf_write_data, 0);
        chk("arst_width", rf_write_width, 0);
        chk("arst_werr", width_error, 0);
        chk("arst_busy1", query1_busy, 0);
        chk("arst_busy2", query2_busy, 0);
        chk("arst_a_ready", a_ready, 0);
        chk("arst_b_ready", b_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst");
        chk("post_rst_a_first", pre_a_ready, 1);
        chk("post_rst_b_wait", pre_b_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Port A: in-order pipeline writeback (ALU/load).
  - Port B: long-latency unit (mul/div).
- Round-robin arbitration with valid/ready handshakes, plus one registered output stage that drives the register-file write port.
- Holds a per-register pending scoreboard so decode can stall on registers still owned by port B.

Parameters:
- REG_NUMBER, 32, number of architectural registers.
- REG_ADDR_WIDTH, $clog2(REG_NUMBER), register address width.
- DATA_WIDTH, 32, write data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A request accepted this cycle.
- a_addr  in  REG_ADDR_WIDTH  port A destination register.
- a_width  in  4  port A write width code (1/2/4 bytes).
- a_data  in  DATA_WIDTH  port A write data.
- b_valid, b_ready, b_addr, b_width, b_data  same as A, for port B.
- issue_valid  in  1  long-latency op issued this cycle; marks issue_addr pending.
- issue_addr  in  REG_ADDR_WIDTH  destination of the issued op.
- query1_addr, query2_addr  in  REG_ADDR_WIDTH  decode source registers.
- query1_busy, query2_busy  out  1  source register still pending.
- rf_write_enable  out  1  to register-file write_enable.
- rf_write_width  out  4  to register-file write_width.
- rf_write_reg_addr  out  REG_ADDR_WIDTH  to register-file write address.
- rf_write_data  out  DATA_WIDTH  to register-file write data.
- width_error  out  1  sticky flag: an illegal width code was accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - all rf_* outputs 0; width_error 0; all pending bits 0.
  - last_grant = B, so A wins the first tie.
- Arbitration (combinational):
  - Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: grant the port not granted last; the other port's ready is 0.
  - last_grant updates only on an accepted transfer.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - A requester must hold addr/width/data stable while valid && !ready.
- Latency:
  - A transfer accepted at edge N is registered into the rf_* outputs at edge N.
  - The register file commits it at edge N+1.
  - The output stage never back-pressures: one transfer per cycle sustained.
- Register 0:
  - Transfers to addr 0 are accepted (ready asserted normally).
  - rf_write_enable stays 0 for them.
- Width codes:
  - Legal codes are 1, 2 and 4.
  - Any other code: the transfer is accepted, rf_write_enable is 0, and width_error is set until reset.
- Scoreboard, one pending bit per register:
  - Set: issue_valid at edge, when issue_addr != 0.
  - Clear: when a port B write to that address is presented on the rf_* outputs, i.e. at the same edge N+1 at which the register file commits it.
  - Port A writes never clear pending bits.
  - Set and clear of the same address at the same edge: set wins (newer owner).
  - issue_valid to an address already pending is legal; the bit stays 1 (no counting).
- Query:
  - query*_busy = pending[query*_addr].
  - Additionally forced to 0 when the current rf_* outputs hold a port B write to that address.
  - This matches the register file's write bypass, so no extra stall cycle is needed.
  - Query of register 0 always returns 0.
- Reset mid-operation:
  - Any in-flight output-stage write is dropped (rf_write_enable 0).
  - The scoreboard is cleared.
  - Requesters re-present their requests after reset is released.

Decomposition:
- Shared package holds:
  - the width-code constants BYTE=1, HALF=2, WORD=4, shared with the register file;
  - the port-select encoding PORT_A=0, PORT_B=1.
- One natural sub-module: regfile_scoreboard, holding the pending vector with set/clear/query logic.
- The arbiter and output stage stay in the top module.

Test Plan:
- Release reset; a_valid=1, a_addr=5, a_width=4, a_data=0xDEADBEEF.
  - Expect a_ready=1 in that cycle.
  - Next cycle: rf_write_enable=1, rf_write_reg_addr=5, rf_write_data=0xDEADBEEF.
- Hold a_valid and b_valid high for 4 cycles.
  - Expect grants in the order A, B, A, B.
  - Each port's ready toggles accordingly; the losing port's data stays held stable.
- issue_valid, issue_addr=7; then query1_addr=7.
  - Expect busy=1.
  - Then a B write to addr 7 is accepted at edge N; during the cycle after N, query1_busy=0 and rf_write_enable=1.
- issue_valid with addr 9 in the same cycle that a port B write to addr 9 sits in the output stage.
  - Expect pending[9]=1 afterwards.
- Accepted writes to addr 0, and a write with a_width=3.
  - Expect rf_write_enable=0 for both.
  - Expect width_error=1 and held until reset.
- Assert reset low mid-stream with pending bits set and a write in the output stage.
  - Expect all outputs 0 and all query*_busy=0 immediately, without waiting for a clock edge.
